// File: rtl/multicycle_cu_if.sv
// Control bundle between the multicycle MIPS control unit (master) and its datapath (slave).
// Carries the opcode/memory-ready inputs and every mux select and write enable.
interface multicycle_cu_if;
   logic [5:0] Op;
   logic       MemReady;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic [1:0] PCSource;
   logic [1:0] ALUOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       RegWrite;
   logic       RegDst;
   logic [3:0] State;
   logic       Illegal;
   logic       BusFault;

   modport master (
      input  Op, MemReady,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, State,
             Illegal, BusFault
   );

   modport slave (
      output Op, MemReady,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, State,
             Illegal, BusFault
   );
endinterface

// File: rtl/multicycle_cu.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath with memory wait-state timeout.
// Optional macro ADDI_EN adds the addi path (ADDIEX/ADDIWB); otherwise opcode 0x08 is illegal.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 when memory ready
//   DECODE | read registers, branch target into ALUOut, dispatch on Op
//   MEMADR | effective address for lw/sw
//   MEMRD  | data read at ALUOut, wait for memory ready
//   MEMWB  | write MDR to rt
//   MEMWR  | data write at ALUOut, wait for memory ready
//   EXEC   | R-type ALU operation
//   RWB    | write ALUOut to rd
//   BRANCH | compare, conditional PC load
//   JUMP   | PC <= jump target
//   ADDIEX | A + sign-extended imm (ADDI_EN only)
//   ADDIWB | write ALUOut to rt (ADDI_EN only)
module multicycle_cu #(
   parameter int unsigned WAIT_LIMIT = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   multicycle_cu_if.master  bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
`ifdef ADDI_EN
      ,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Fault fires on the WAIT_LIMIT-th consecutive not-ready cycle.
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   logic       mem_state;
   logic       wait_fault;

   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       mem_to_reg;
   logic       ir_write;
   logic [1:0] pc_source;
   logic [1:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       reg_write;
   logic       reg_dst;
   logic       illegal;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      mem_state     = 1'b0;
      wait_fault    = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      pc_source     = 2'b00;
      alu_op        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      illegal       = 1'b0;

      unique case (state_q)
         FETCH: begin
            mem_state = 1'b1;
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = bus.MemReady;
            pc_write  = bus.MemReady;
            if (bus.MemReady) state_d = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            if (bus.Op == OP_LW || bus.Op == OP_SW) begin
               state_d = MEMADR;
            end else if (bus.Op == OP_RTYPE) begin
               state_d = EXEC;
            end else if (bus.Op == OP_BEQ) begin
               state_d = BRANCH;
            end else if (bus.Op == OP_J) begin
               state_d = JUMP;
`ifdef ADDI_EN
            end else if (bus.Op == OP_ADDI) begin
               state_d = ADDIEX;
`endif
            end else begin
               illegal = 1'b1;
               state_d = FETCH;
            end
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (bus.Op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_state = 1'b1;
            mem_read  = 1'b1;
            iord      = 1'b1;
            if (bus.MemReady) state_d = MEMWB;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
         end
         MEMWR: begin
            mem_state = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            if (bus.MemReady) state_d = FETCH;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = RWB;
         end
         RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_d       = FETCH;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = FETCH;
         end
`ifdef ADDI_EN
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
`endif
         default: begin
            state_d = FETCH;
         end
      endcase

      // Counter is zero outside memory states, so every entry into one starts clean.
      if (mem_state && !bus.MemReady) begin
         if (wait_cnt_q >= WAIT_LAST) begin
            wait_fault = 1'b1;
            state_d    = FETCH;
            wait_cnt_d = '0;
         end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end
   end

   // Reset forces every output low combinationally so an abandoned write never lands.
   always_comb begin
      bus.PCWrite     = !Reset && pc_write;
      bus.PCWriteCond = !Reset && pc_write_cond;
      bus.IorD        = !Reset && iord;
      bus.MemRead     = !Reset && mem_read;
      bus.MemWrite    = !Reset && mem_write;
      bus.MemtoReg    = !Reset && mem_to_reg;
      bus.IRWrite     = !Reset && ir_write;
      bus.PCSource    = Reset ? 2'b00 : pc_source;
      bus.ALUOp       = Reset ? 2'b00 : alu_op;
      bus.ALUSrcA     = !Reset && alu_src_a;
      bus.ALUSrcB     = Reset ? 2'b00 : alu_src_b;
      bus.RegWrite    = !Reset && reg_write;
      bus.RegDst      = !Reset && reg_dst;
      bus.State       = Reset ? 4'd0 : state_q;
      bus.Illegal     = !Reset && illegal;
      bus.BusFault    = !Reset && wait_fault;
   end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: per-cycle vector queue built from instruction-level paths,
// checked every cycle against a state->control table.
module tb_multicycle_cu;

   localparam int WL = 8;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       mr;
      logic [3:0] st;
      logic       ill;
      logic       bf;
   } vec_t;

   logic Clock;
   logic Reset;
   multicycle_cu_if bus ();

   multicycle_cu #(.WAIT_LIMIT(WL)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   vec_t vq[$];
   vec_t cur;
   bit   active = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
   //                     PCSource[2] ALUOp[2] ALUSrcA ALUSrcB[2] RegWrite RegDst
   function automatic logic [15:0] ctrl_of(input int st, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd;
      logic [1:0] pcs, aop, srcb;
      pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; m2r = 0; irw = 0;
      srca = 0; rw = 0; rd = 0; pcs = 0; aop = 0; srcb = 0;
      case (st)
         0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
         1:  srcb = 2'b11;
         2:  begin srca = 1; srcb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin srca = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         9:  begin pcw = 1; pcs = 2'b10; end
         10: begin srca = 1; srcb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, srca, srcb, rw, rd};
   endfunction

   // States an opcode visits after DECODE; legal=0 means DECODE flags it and returns to FETCH.
   task automatic get_path(input logic [5:0] op, output bit legal, output int plen,
                           output int p0, output int p1, output int p2);
      legal = 1; plen = 0; p0 = 0; p1 = 0; p2 = 0;
      case (op)
         6'h23: begin plen = 3; p0 = 2; p1 = 3; p2 = 4; end
         6'h2B: begin plen = 2; p0 = 2; p1 = 5; end
         6'h00: begin plen = 2; p0 = 6; p1 = 7; end
         6'h04: begin plen = 1; p0 = 8; end
         6'h02: begin plen = 1; p0 = 9; end
`ifdef ADDI_EN
         6'h08: begin plen = 2; p0 = 10; p1 = 11; end
`endif
         default: legal = 0;
      endcase
   endtask

   task automatic push(input logic rst, input logic [5:0] op, input logic mr,
                       input int st, input logic ill, input logic bf);
      vec_t v;
      v.rst = rst; v.op = op; v.mr = mr; v.st = 4'(st); v.ill = ill; v.bf = bf;
      vq.push_back(v);
   endtask

   // n not-ready cycles then one ready cycle; the WL-th consecutive wait faults instead.
   task automatic push_wait(input int st, input int n, input logic [5:0] op, output bit aborted);
      aborted = 0;
      for (int i = 0; i < n; i++) begin
         if (i == WL - 1) begin
            push(0, op, 0, st, 0, 1);
            aborted = 1;
            return;
         end
         push(0, op, 0, st, 0, 0);
      end
      push(0, op, 1, st, 0, 0);
   endtask

   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      bit legal, ab;
      int plen, p[3];
      push_wait(0, fw, op, ab);
      if (ab) return;
      get_path(op, legal, plen, p[0], p[1], p[2]);
      push(0, op, 1, 1, !legal, 0);
      for (int k = 0; k < plen; k++) begin
         if (p[k] == 3 || p[k] == 5) begin
            push_wait(p[k], mw, op, ab);
            if (ab) return;
         end else begin
            push(0, op, 1, p[k], 0, 0);
         end
      end
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   // Single compare process: every driven cycle, 2 time units after inputs change.
   always @(negedge Clock) begin
      #2;
      if (active) begin
         logic [15:0] dut_ctrl, exp_ctrl;
         dut_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                     bus.MemtoReg, bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcA,
                     bus.ALUSrcB, bus.RegWrite, bus.RegDst};
         exp_ctrl = cur.rst ? 16'h0 : ctrl_of(int'(cur.st), cur.mr);
         check("ctrl", dut_ctrl, exp_ctrl);
         check("state", 16'(bus.State), cur.rst ? 16'h0 : 16'(cur.st));
         check("illegal", 16'(bus.Illegal), cur.rst ? 16'h0 : 16'(cur.ill));
         check("busfault", 16'(bus.BusFault), cur.rst ? 16'h0 : 16'(cur.bf));
         check("rd_wr_excl", 16'(bus.MemRead & bus.MemWrite), 16'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   legal;
      int   plen, q0, q1, q2;
      Reset = 1'b1;
      bus.Op = 6'h00;
      bus.MemReady = 1'b1;

      // Pin the model against hand-computed words.
      check("model_fetch", ctrl_of(0, 1'b1), 16'h9204);
      check("model_fetch_wait", ctrl_of(0, 1'b0), 16'h1004);
      check("model_branch", ctrl_of(8, 1'b1), 16'h40B0);
      check("model_jump", ctrl_of(9, 1'b1), 16'h8100);
      check("model_memwb", ctrl_of(4, 1'b1), 16'h0402);
      get_path(6'h23, legal, plen, q0, q1, q2);
      check("model_lw_latency", 16'(plen + 2), 16'd5);
      get_path(6'h04, legal, plen, q0, q1, q2);
      check("model_beq_latency", 16'(plen + 2), 16'd3);

      push(1, 6'h00, 1, 0, 0, 0);
      push(1, 6'h00, 1, 0, 0, 0);
      run_instr(6'h23, 0, 0);
      run_instr(6'h00, 0, 0);
      run_instr(6'h04, 0, 0);
      run_instr(6'h02, 0, 0);
      run_instr(6'h2B, 0, 0);
      run_instr(6'h2B, 0, 3);
      run_instr(6'h23, 2, 5);
      run_instr(6'h00, WL, 0);
      run_instr(6'h00, 3, 0);
      run_instr(6'h08, 0, 0);
      run_instr(6'h3F, 1, 0);
      run_instr(6'h2B, 0, WL);
      run_instr(6'h23, 0, WL + 2);
      run_instr(6'h02, WL - 1, 0);
      // Reset during MEMWR abandons the store.
      push(0, 6'h2B, 1, 0, 0, 0);
      push(0, 6'h2B, 1, 1, 0, 0);
      push(0, 6'h2B, 1, 2, 0, 0);
      push(0, 6'h2B, 0, 5, 0, 0);
      push(0, 6'h2B, 0, 5, 0, 0);
      push(1, 6'h2B, 0, 5, 0, 0);
      run_instr(6'h04, 0, 0);
      run_instr(6'h23, 0, 0);

      foreach (vq[i]) begin
         @(negedge Clock);
         Reset        = vq[i].rst;
         bus.Op       = vq[i].op;
         bus.MemReady = vq[i].mr;
         cur          = vq[i];
         cyc          = i;
         active       = 1'b1;
      end
      @(negedge Clock);
      active = 1'b0;
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
